// File: rtl/ring_output_ctrl_pkg.sv
// Shared ring-router constants and VC helpers, common to the switch arbiter,
// input controller and output controller.
package ring_output_ctrl_pkg;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned VcBit     = 63;
  localparam int unsigned DirBit    = 62;
  localparam int unsigned HopHi     = 61;
  localparam int unsigned HopLo     = 58;
  localparam int unsigned CntWidth  = 16;

  typedef enum logic {
    VcEven = 1'b0,
    VcOdd  = 1'b1
  } vc_e;

  // The VC that is not being arbitrated internally is the one allowed onto the link.
  function automatic vc_e drain_vc(logic polarity);
    return polarity ? VcEven : VcOdd;
  endfunction

endpackage

// File: rtl/ring_output_ctrl_if.sv
// Arbiter write ports, empty flags, link handshake and status of one ring output port.
interface ring_output_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  polarity;
  logic [DATA_WIDTH-1:0] even_wr_data;
  logic                  even_wr_enable;
  logic                  even_empty;
  logic [DATA_WIDTH-1:0] odd_wr_data;
  logic                  odd_wr_enable;
  logic                  odd_empty;
  logic                  link_ready;
  logic                  link_send;
  logic [DATA_WIDTH-1:0] link_data;
  logic [CNT_WIDTH-1:0]  sent_count;
  logic                  err_overflow;
  logic                  err_vc;

  modport master (
    output polarity, even_wr_data, even_wr_enable, odd_wr_data, odd_wr_enable, link_ready,
    input  even_empty, odd_empty, link_send, link_data, sent_count, err_overflow, err_vc
  );

  modport slave (
    input  polarity, even_wr_data, even_wr_enable, odd_wr_data, odd_wr_enable, link_ready,
    output even_empty, odd_empty, link_send, link_data, sent_count, err_overflow, err_vc
  );
endinterface

// File: rtl/ring_output_ctrl_vc_slot.sv
// Single-entry VC buffer. A write is taken when the slot is free or is draining
// on the same edge; otherwise it is dropped and flagged as an overflow.
module ring_output_ctrl_vc_slot #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  drain,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  accept,
  output logic                  overflow
);

  assign accept   = wr_enable && (!full || drain);
  assign overflow = wr_enable && full && !drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_output_ctrl.sv
// Per-port ring output controller: two single-entry VC slots, polarity-selected
// drain onto a registered send/ready link, sent-flit counter and sticky errors.
module ring_output_ctrl
  import ring_output_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned VC_BIT     = VcBit,
  parameter int unsigned CNT_WIDTH  = CntWidth
) (
  input logic               clk,
  input logic               reset,
  ring_output_ctrl_if.slave bus
);

  logic                  even_full, odd_full;
  logic [DATA_WIDTH-1:0] even_data, odd_data;
  logic                  even_accept, odd_accept;
  logic                  even_overflow, odd_overflow;
  logic                  even_drain, odd_drain;
  logic                  even_vc_bad, odd_vc_bad;

  logic                  link_send_q;
  logic [DATA_WIDTH-1:0] link_data_q;
  logic [CNT_WIDTH-1:0]  sent_count_q;
  logic                  err_overflow_q, err_vc_q;

  assign even_drain = bus.link_ready && even_full && (drain_vc(bus.polarity) == VcEven);
  assign odd_drain  = bus.link_ready && odd_full  && (drain_vc(bus.polarity) == VcOdd);

  ring_output_ctrl_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) u_even_slot (
    .clk      (clk),
    .reset    (reset),
    .wr_enable(bus.even_wr_enable),
    .wr_data  (bus.even_wr_data),
    .drain    (even_drain),
    .full     (even_full),
    .data     (even_data),
    .accept   (even_accept),
    .overflow (even_overflow)
  );

  ring_output_ctrl_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) u_odd_slot (
    .clk      (clk),
    .reset    (reset),
    .wr_enable(bus.odd_wr_enable),
    .wr_data  (bus.odd_wr_data),
    .drain    (odd_drain),
    .full     (odd_full),
    .data     (odd_data),
    .accept   (odd_accept),
    .overflow (odd_overflow)
  );

  // Mis-tagged flits are still stored; only the sticky flag records them.
  assign even_vc_bad = even_accept && (vc_e'(bus.even_wr_data[VC_BIT]) != VcEven);
  assign odd_vc_bad  = odd_accept  && (vc_e'(bus.odd_wr_data[VC_BIT])  != VcOdd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_send_q    <= 1'b0;
      link_data_q    <= '0;
      sent_count_q   <= '0;
      err_overflow_q <= 1'b0;
      err_vc_q       <= 1'b0;
    end else begin
      link_send_q <= even_drain || odd_drain;
      if (even_drain) begin
        link_data_q <= even_data;
      end else if (odd_drain) begin
        link_data_q <= odd_data;
      end else begin
        link_data_q <= '0;
      end
      if (even_drain || odd_drain) begin
        sent_count_q <= sent_count_q + CNT_WIDTH'(1);
      end
      if (even_overflow || odd_overflow) begin
        err_overflow_q <= 1'b1;
      end
      if (even_vc_bad || odd_vc_bad) begin
        err_vc_q <= 1'b1;
      end
    end
  end

  assign bus.even_empty   = ~even_full;
  assign bus.odd_empty    = ~odd_full;
  assign bus.link_send    = link_send_q;
  assign bus.link_data    = link_data_q;
  assign bus.sent_count   = sent_count_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_vc       = err_vc_q;

endmodule

// File: tb/tb_ring_output_ctrl.sv
// Randomized and directed bench for ring_output_ctrl against a queue-based
// behavioural model of the two VC slots and the link.
module tb_ring_output_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ring_output_ctrl_if #(.DATA_WIDTH(64), .CNT_WIDTH(16)) bus ();

  ring_output_ctrl #(.DATA_WIDTH(64), .VC_BIT(63), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Model: each slot is a queue holding at most one flit.
  logic [63:0] q_even[$];
  logic [63:0] q_odd[$];
  logic        m_send;
  logic [63:0] m_data;
  logic [15:0] m_cnt;
  logic        m_ov;
  logic        m_vc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_even.delete();
    q_odd.delete();
    m_send = 1'b0;
    m_data = '0;
    m_cnt  = '0;
    m_ov   = 1'b0;
    m_vc   = 1'b0;
  endtask

  // Evaluate one clock edge from the inputs present before it.
  task automatic model_edge();
    logic draining;
    if (bus.polarity) draining = bus.link_ready && (q_even.size() != 0);
    else              draining = bus.link_ready && (q_odd.size() != 0);
    m_send = draining;
    m_data = '0;
    if (draining) begin
      m_data = bus.polarity ? q_even.pop_front() : q_odd.pop_front();
      m_cnt  = m_cnt + 16'd1;
    end
    if (bus.even_wr_enable) begin
      if (q_even.size() == 0) begin
        q_even.push_back(bus.even_wr_data);
        if (bus.even_wr_data[63] != 1'b0) m_vc = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end
    if (bus.odd_wr_enable) begin
      if (q_odd.size() == 0) begin
        q_odd.push_back(bus.odd_wr_data);
        if (bus.odd_wr_data[63] != 1'b1) m_vc = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("link_send", 64'(bus.link_send), 64'(m_send));
    check_eq("link_data", bus.link_data, m_data);
    check_eq("sent_count", 64'(bus.sent_count), 64'(m_cnt));
    check_eq("err_overflow", 64'(bus.err_overflow), 64'(m_ov));
    check_eq("err_vc", 64'(bus.err_vc), 64'(m_vc));
    check_eq("even_empty", 64'(bus.even_empty), 64'(q_even.size() == 0));
    check_eq("odd_empty", 64'(bus.odd_empty), 64'(q_odd.size() == 0));
  endtask

  task automatic drive(input logic pol, input logic lr, input logic ewe, input logic [63:0] ewd,
                       input logic owe, input logic [63:0] owd);
    bus.polarity       = pol;
    bus.link_ready     = lr;
    bus.even_wr_enable = ewe;
    bus.even_wr_data   = ewd;
    bus.odd_wr_enable  = owe;
    bus.odd_wr_data    = owd;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_outputs();
  endtask

  localparam logic [63:0] OddTag = 64'h8000_0000_0000_0000;

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    do_reset();

    // Idle after reset.
    step();
    check_eq("t1_even_empty", 64'(bus.even_empty), 64'd1);
    check_eq("t1_sent", 64'(bus.sent_count), 64'd0);

    // Write even, flip polarity, expect the flit one cycle later.
    drive(1'b0, 1'b0, 1'b1, 64'hA5, 1'b0, '0);
    step();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    step();
    check_eq("t2_send", 64'(bus.link_send), 64'd1);
    check_eq("t2_data", bus.link_data, 64'hA5);
    check_eq("t2_empty", 64'(bus.even_empty), 64'd1);
    check_eq("t2_cnt", 64'(bus.sent_count), 64'd1);

    // Back-pressure holds the odd flit.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, OddTag | 64'h11);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step();
    check_eq("t3_hold_send", 64'(bus.link_send), 64'd0);
    check_eq("t3_hold_empty", 64'(bus.odd_empty), 64'd0);
    bus.link_ready = 1'b1;
    step();
    check_eq("t3_data", bus.link_data, OddTag | 64'h11);
    step();
    check_eq("t3_once", 64'(bus.link_send), 64'd0);

    // Same-edge drain and write on the odd slot.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, OddTag | 64'h21);
    step();
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, OddTag | 64'h22);
    step();
    check_eq("t4_data", bus.link_data, OddTag | 64'h21);
    check_eq("t4_resident", 64'(bus.odd_empty), 64'd0);
    check_eq("t4_ovf", 64'(bus.err_overflow), 64'd0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    step();
    check_eq("t4_new_data", bus.link_data, OddTag | 64'h22);

    // Overflow on a non-draining full even slot, then a mis-tagged even write.
    drive(1'b0, 1'b0, 1'b1, 64'h30, 1'b0, '0);
    step();
    bus.even_wr_data = 64'h33;
    step();
    check_eq("t5_ovf", 64'(bus.err_overflow), 64'd1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    step();
    check_eq("t5_kept", bus.link_data, 64'h30);
    drive(1'b0, 1'b0, 1'b1, OddTag | 64'h44, 1'b0, '0);
    step();
    check_eq("t5_vc", 64'(bus.err_vc), 64'd1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    step();
    check_eq("t5_stored", bus.link_data, OddTag | 64'h44);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] ed, od;
      ed = {$urandom, $urandom};
      od = {$urandom, $urandom};
      ed[63] = ($urandom_range(0, 15) == 0);
      od[63] = ($urandom_range(0, 15) != 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ed, 1'($urandom_range(0, 1)), od);
      step();
    end

    // Counter wrap: stream odd flits at one per cycle.
    do_reset();
    while (m_cnt != 16'hFFFF) begin
      drive(1'b0, 1'b1, 1'b0, '0, 1'b1, OddTag | 64'($urandom));
      step();
    end
    check_eq("t6_max", 64'(bus.sent_count), 64'hFFFF);
    step();
    check_eq("t6_wrap", 64'(bus.sent_count), 64'd0);

    // Both slots full with a send in flight, then asynchronous reset.
    drive(1'b0, 1'b1, 1'b1, 64'h55, 1'b1, OddTag | 64'h66);
    step();
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    check_eq("t6_pre_send", 64'(bus.link_send), 64'd1);
    check_eq("t6_pre_even", 64'(bus.even_empty), 64'd0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check_eq("t6_async_send", 64'(bus.link_send), 64'd0);
    check_eq("t6_async_odd", 64'(bus.odd_empty), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
